// File: rtl/pl_lut_pkg.sv
// -----------------------------------------------------------------------------
// pl_lut_pkg
// Shared definitions for the pseudo-linear learning lookup table:
//   - lut_state_t : controller states (CLEAR sweeps the table, RUN streams)
//   - init_val    : counter value written by the clear sweep (just below MID)
//   - mid_val     : threshold at or above which a counter predicts a 1
//   - sat_step    : one saturating up/down vote on a cnt_w-bit counter
// The helpers take the counter width as an argument so one package serves
// every parameterisation of the table.
// -----------------------------------------------------------------------------
package pl_lut_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } lut_state_t;

   // Cleared counters sit one below the decision threshold, so an untrained
   // entry predicts 0 and a single up-vote is enough to flip it to 1.
   function automatic int init_val(input int cnt_w);
      return (1 << (cnt_w - 1)) - 1;
   endfunction

   function automatic int mid_val(input int cnt_w);
      return 1 << (cnt_w - 1);
   endfunction

   // Saturating vote: up-votes stop at all-ones, down-votes stop at zero.
   function automatic logic [31:0] sat_step(input logic [31:0] cnt,
                                            input logic        up,
                                            input int          cnt_w);
      logic [31:0] max_cnt;
      max_cnt = (32'd1 << cnt_w) - 32'd1;
      if (up) begin
         return (cnt >= max_cnt) ? max_cnt : cnt + 32'd1;
      end
      return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
   endfunction

endpackage

// File: rtl/pseudo_linear_lut_vote_ram.sv
// -----------------------------------------------------------------------------
// vote_ram
// Simple dual-port RAM holding one word of packed vote counters per address.
// Registered read; on a same-address read/write in one cycle the read returns
// the old contents (read-first). The top level forwards around that.
// Ports:
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (sampled every cycle)
//   rdata  : read data, valid the cycle after raddr is presented
// -----------------------------------------------------------------------------
module vote_ram #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   // Write and registered read share one clocked block; because both are
   // non-blocking, a colliding read picks up the word before this write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/pseudo_linear_lut.sv
// -----------------------------------------------------------------------------
// pseudo_linear_lut
// Online-trained lookup table: each feature address owns NUM_OUT saturating
// vote counters. Train samples vote counters up/down by their label, test
// samples are only scored. Predictions are the counter MSB-threshold taken
// before the sample's own update. Three-stage pipeline:
//   S0 accept + RAM read issue, S1 read data + forwarding + vote compute,
//   S2 write-back + registered outputs.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart table clear, zero score, drop in-flight samples
//   in_valid/in_ready, x, y, test : sample stream (test=1 scores only)
//   out_valid, result             : one pulse per sample with its prediction
//   score, samples                : matching / total test samples (saturating)
//   busy                          : table clear sweep in progress
// -----------------------------------------------------------------------------
module pseudo_linear_lut
   import pl_lut_pkg::*;
#(
   parameter int ADDR_W  = 14,
   parameter int NUM_OUT = 1,
   parameter int CNT_W   = 4,
   parameter int SCORE_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ADDR_W-1:0]  x,
   input  logic [NUM_OUT-1:0] y,
   input  logic               test,
   output logic               out_valid,
   output logic [NUM_OUT-1:0] result,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] samples,
   output logic               busy
);

   localparam int DW = NUM_OUT * CNT_W;

   localparam logic [CNT_W-1:0]   INIT_CNT  = CNT_W'(init_val(CNT_W));
   localparam logic [CNT_W-1:0]   MID_CNT   = CNT_W'(mid_val(CNT_W));
   localparam logic [DW-1:0]      INIT_WORD = {NUM_OUT{INIT_CNT}};
   localparam logic [ADDR_W-1:0]  LAST_ADDR = '1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   lut_state_t state, state_next;
   logic [ADDR_W-1:0] sweep_ptr;

   logic accept;

   logic               s1_valid;
   logic [ADDR_W-1:0]  s1_addr;
   logic [NUM_OUT-1:0] s1_y;
   logic               s1_test;
   logic [DW-1:0]      s1_cnt;
   logic [DW-1:0]      s1_new;
   logic [NUM_OUT-1:0] s1_pred;

   logic               s2_valid;
   logic [ADDR_W-1:0]  s2_addr;
   logic [DW-1:0]      s2_wdata;
   logic [NUM_OUT-1:0] s2_result;
   logic [NUM_OUT-1:0] s2_y;
   logic               s2_test;

   logic               wb_valid;
   logic [ADDR_W-1:0]  wb_addr;
   logic [DW-1:0]      wb_data;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DW-1:0]     ram_wdata;
   logic [DW-1:0]     ram_rdata;

   assign in_ready = (state == RUN) && !clear;
   assign busy     = (state == CLEAR);
   assign accept   = in_valid && in_ready;

   vote_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DW)
   ) u_vote_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (x),
      .rdata (ram_rdata)
   );

   // Controller state register. Reset lands in CLEAR so the table is always
   // swept to a known state before the first sample is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
      end else begin
         state <= state_next;
      end
   end

   // Next state: clear always restarts the sweep; the sweep hands over to RUN
   // once the top address has been written.
   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = CLEAR;
      end else begin
         case (state)
            CLEAR:   if (sweep_ptr == LAST_ADDR) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
         endcase
      end
   end

   // Sweep pointer walks the table once per clear, ascending from zero, and
   // parks at zero outside the sweep so a restart always begins at the bottom.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_ptr <= '0;
      end else if (clear || state != CLEAR) begin
         sweep_ptr <= '0;
      end else begin
         sweep_ptr <= sweep_ptr + ADDR_W'(1);
      end
   end

   // The single RAM write port is owned by the sweep while clearing and by
   // the S2 write-back while running. A write-back coinciding with clear is
   // dropped because that sample is being discarded.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = s2_addr;
      ram_wdata = s2_wdata;
      if (state == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = sweep_ptr;
         ram_wdata = INIT_WORD;
      end else begin
         ram_we = s2_valid && !s2_test && !clear;
      end
   end

   // S1 counter source. The RAM word can be stale in two ways: the previous
   // sample's update is still sitting in S2, or the one before it was written
   // on the same edge our read was issued (read-first). The newest update wins.
   always_comb begin
      s1_cnt = ram_rdata;
      if (wb_valid && wb_addr == s1_addr) begin
         s1_cnt = wb_data;
      end
      if (s2_valid && !s2_test && s2_addr == s1_addr) begin
         s1_cnt = s2_wdata;
      end
   end

   // Prediction is taken from the counters before this sample votes; the new
   // word is always computed but only written back for train samples.
   always_comb begin
      s1_pred = '0;
      s1_new  = s1_cnt;
      for (int k = 0; k < NUM_OUT; k++) begin
         s1_pred[k] = (s1_cnt[k*CNT_W +: CNT_W] >= MID_CNT);
         s1_new[k*CNT_W +: CNT_W] =
            CNT_W'(sat_step(32'(s1_cnt[k*CNT_W +: CNT_W]), s1_y[k], CNT_W));
      end
   end

   // Pipeline registers. clear empties every stage, including the record of
   // the last write that the distance-two forward relies on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_addr   <= '0;
         s1_y      <= '0;
         s1_test   <= 1'b0;
         s2_valid  <= 1'b0;
         s2_addr   <= '0;
         s2_wdata  <= '0;
         s2_result <= '0;
         s2_y      <= '0;
         s2_test   <= 1'b0;
         wb_valid  <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
      end else begin
         if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            wb_valid <= 1'b0;
         end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            wb_valid <= s2_valid && !s2_test;
         end
         if (accept) begin
            s1_addr <= x;
            s1_y    <= y;
            s1_test <= test;
         end
         s2_addr   <= s1_addr;
         s2_wdata  <= s1_new;
         s2_result <= s1_pred;
         s2_y      <= s1_y;
         s2_test   <= s1_test;
         wb_addr   <= s2_addr;
         wb_data   <= s2_wdata;
      end
   end

   // Output stage and scorer. Only test samples count; a hit needs every
   // label bit to match. Both counters stick at all-ones rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         score     <= '0;
         samples   <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         score     <= '0;
         samples   <= '0;
      end else begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            result <= s2_result;
         end
         if (s2_valid && s2_test) begin
            if (samples != SCORE_MAX) begin
               samples <= samples + SCORE_W'(1);
            end
            if (s2_result == s2_y && score != SCORE_MAX) begin
               score <= score + SCORE_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pseudo_linear_lut.sv
// -----------------------------------------------------------------------------
// tb_pseudo_linear_lut
// Self-checking bench for pseudo_linear_lut with a 16-entry table, 4 label
// bits, 4-bit counters and 6-bit score counters. A serial software model
// (one sample at a time, plain arrays) predicts every output; a compare
// process checks out_valid/result/score/samples every cycle, and directed
// sequences pin the model with hand-worked literal values.
// -----------------------------------------------------------------------------
module tb_pseudo_linear_lut;

   localparam int AW = 4;
   localparam int NO = 4;
   localparam int CW = 4;
   localparam int SW = 6;
   localparam int DEPTH   = 1 << AW;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int CNT_MID = 1 << (CW - 1);
   localparam int SC_MAX  = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] x;
   logic [NO-1:0] y;
   logic          test;
   logic          out_valid;
   logic [NO-1:0] result;
   logic [SW-1:0] score;
   logic [SW-1:0] samples;
   logic          busy;

   pseudo_linear_lut #(
      .ADDR_W  (AW),
      .NUM_OUT (NO),
      .CNT_W   (CW),
      .SCORE_W (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .test      (test),
      .out_valid (out_valid),
      .result    (result),
      .score     (score),
      .samples   (samples),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      logic [NO-1:0] res;
      int            sc;
      int            smp;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            model_cnt [DEPTH][NO];
   int            model_score;
   int            model_samples;
   int            cur_score;
   int            cur_samples;
   exp_t          exp_q [$];
   logic [NO-1:0] dut_log [$];

   // Edge counter used to schedule when each expectation falls due.
   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d",
                  name, actual, expected, cyc);
      end
   endtask

   // Forget everything in flight and return the model to a freshly swept table.
   task automatic flushModel();
      exp_q.delete();
      for (int a = 0; a < DEPTH; a++)
         for (int k = 0; k < NO; k++)
            model_cnt[a][k] = CNT_MID - 1;
      model_score   = 0;
      model_samples = 0;
      cur_score     = 0;
      cur_samples   = 0;
   endtask

   // Serial reference: predict from the table as it stands, then vote or score.
   task automatic modelStep(input logic [AW-1:0] xa, input logic [NO-1:0] ya,
                            input logic t);
      logic [NO-1:0] pred;
      exp_t e;
      for (int k = 0; k < NO; k++)
         pred[k] = (model_cnt[xa][k] >= CNT_MID);
      if (!t) begin
         for (int k = 0; k < NO; k++) begin
            if (ya[k]) model_cnt[xa][k] = (model_cnt[xa][k] < CNT_MAX) ? model_cnt[xa][k] + 1 : CNT_MAX;
            else       model_cnt[xa][k] = (model_cnt[xa][k] > 0) ? model_cnt[xa][k] - 1 : 0;
         end
      end else begin
         if (model_samples < SC_MAX) model_samples++;
         if (pred == ya && model_score < SC_MAX) model_score++;
      end
      e.due = cyc + 3;
      e.res = pred;
      e.sc  = model_score;
      e.smp = model_samples;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge; a clear cycle must refuse
   // the sample and wipes the model, otherwise an accepted sample feeds it.
   task automatic applyStimulus(input logic v, input logic [AW-1:0] xa,
                                input logic [NO-1:0] ya, input logic t,
                                input logic clr);
      @(negedge clk);
      in_valid = v;
      x        = xa;
      y        = ya;
      test     = t;
      clear    = clr;
      #1;
      if (clr) begin
         checkOutput("in_ready_during_clear", 32'(in_ready), 0);
         flushModel();
      end else if (v && in_ready) begin
         modelStep(xa, ya, t);
      end
   endtask

   task automatic drain();
      repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   // Count falling edges with busy high starting from the current one.
   task automatic countBusyHere();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checkOutput("busy_cycles", n, DEPTH);
      checkOutput("in_ready_after_sweep", 32'(in_ready), 1);
   endtask

   task automatic randomBurst(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, DEPTH - 1))
                                                   : AW'($urandom_range(0, 2)),
                       NO'($urandom_range(0, (1 << NO) - 1)),
                       ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 199) == 0));
      end
   endtask

   // Compare process: shortly after every rising edge, the oldest expectation
   // must appear exactly on its due cycle; otherwise outputs must be idle and
   // the score counters must hold their last value.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               checkOutput("out_valid", 32'(out_valid), 1);
               checkOutput("result", 32'(result), 32'(e.res));
               checkOutput("score", 32'(score), e.sc);
               checkOutput("samples", 32'(samples), e.smp);
               cur_score   = e.sc;
               cur_samples = e.smp;
            end else begin
               checkOutput("out_valid_idle", 32'(out_valid), 0);
               checkOutput("score_hold", 32'(score), cur_score);
               checkOutput("samples_hold", 32'(samples), cur_samples);
            end
            if (out_valid) dut_log.push_back(result);
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      x        = '0;
      y        = '0;
      test     = 1'b0;
      flushModel();
      repeat (3) @(negedge clk);

      // Reset values while held in reset.
      checkOutput("rst_in_ready", 32'(in_ready), 0);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_result", 32'(result), 0);
      checkOutput("rst_score", 32'(score), 0);
      checkOutput("rst_samples", 32'(samples), 0);
      checkOutput("rst_busy", 32'(busy), 1);
      rst_n = 1'b1;
      countBusyHere();

      // Five back-to-back trains of x=3 on label bit 0, then one test.
      dut_log.delete();
      repeat (5) applyStimulus(1'b1, 4'd3, 4'b0001, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd3, 4'b0001, 1'b1, 1'b0);
      drain();
      checkOutput("b2b_count", dut_log.size(), 6);
      checkOutput("b2b_first", 32'(dut_log[0]), 0);
      checkOutput("b2b_fwd1", 32'(dut_log[1]), 1);
      checkOutput("b2b_last", 32'(dut_log[4]), 1);
      checkOutput("b2b_test", 32'(dut_log[5]), 1);
      checkOutput("b2b_score", 32'(score), 1);
      checkOutput("b2b_samples", 32'(samples), 1);

      // Saturation at both ends of the counter range.
      dut_log.delete();
      repeat (20) applyStimulus(1'b1, 4'd5, 4'b0001, 1'b0, 1'b0);
      repeat (16) applyStimulus(1'b1, 4'd5, 4'b0000, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd5, 4'b0000, 1'b1, 1'b0);
      drain();
      checkOutput("sat_count", dut_log.size(), 37);
      checkOutput("sat_top", 32'(dut_log[20]), 1);
      checkOutput("sat_down8", 32'(dut_log[27]), 1);
      checkOutput("sat_down9", 32'(dut_log[28]), 0);
      checkOutput("sat_test", 32'(dut_log[36]), 0);
      checkOutput("sat_score", 32'(score), 2);
      checkOutput("sat_samples", 32'(samples), 2);

      // Multi-bit label: one train, then a matching and a mismatching test.
      dut_log.delete();
      applyStimulus(1'b1, 4'd9, 4'b1010, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd9, 4'b1010, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'd9, 4'b1011, 1'b1, 1'b0);
      drain();
      checkOutput("multi_hit", 32'(dut_log[1]), 4'b1010);
      checkOutput("multi_miss", 32'(dut_log[2]), 4'b1010);
      checkOutput("multi_score", 32'(score), 3);
      checkOutput("multi_samples", 32'(samples), 4);

      // Interleaved addresses: forwarding at distance two.
      dut_log.delete();
      applyStimulus(1'b1, 4'd1, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd1, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd1, 4'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd2, 4'hF, 1'b0, 1'b0);
      drain();
      checkOutput("ilv_first", 32'(dut_log[0]), 0);
      checkOutput("ilv_fwd2", 32'(dut_log[2]), 4'hF);
      checkOutput("ilv_third", 32'(dut_log[4]), 4'hF);
      checkOutput("ilv_other", 32'(dut_log[5]), 0);

      // clear with two samples in flight and a sample offered alongside it.
      repeat (2) applyStimulus(1'b1, 4'd7, 4'hF, 1'b0, 1'b0);
      drain();
      dut_log.delete();
      applyStimulus(1'b1, 4'd7, 4'hF, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'd7, 4'hF, 1'b1, 1'b0);
      applyStimulus(1'b1, 4'd7, 4'hF, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      clear    = 1'b0;
      countBusyHere();
      applyStimulus(1'b1, 4'd7, 4'hF, 1'b1, 1'b0);
      drain();
      checkOutput("clr_outputs", dut_log.size(), 1);
      checkOutput("clr_erased", 32'(dut_log[0]), 0);
      checkOutput("clr_score", 32'(score), 0);
      checkOutput("clr_samples", 32'(samples), 1);

      // Score counters saturate instead of wrapping.
      repeat (70) applyStimulus(1'b1, 4'd3, 4'h0, 1'b1, 1'b0);
      drain();
      checkOutput("score_sat", 32'(score), SC_MAX);
      checkOutput("samples_sat", 32'(samples), SC_MAX);

      // Random traffic with occasional clears.
      randomBurst(600);

      // Asynchronous reset in the middle of the stream.
      @(negedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      clear    = 1'b0;
      #1;
      checkOutput("async_out_valid", 32'(out_valid), 0);
      checkOutput("async_score", 32'(score), 0);
      checkOutput("async_samples", 32'(samples), 0);
      checkOutput("async_busy", 32'(busy), 1);
      checkOutput("async_in_ready", 32'(in_ready), 0);
      flushModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      countBusyHere();

      randomBurst(150);
      drain();
      checkOutput("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
